// File: rtl/if_fetch_unit.sv
// Fetch stage front end: PC register, next-PC redirect, IF/ID register.
// Bubbles and faulting fetches never redirect; redirects honour the delay slot.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] jr_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        if_id_fault,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] IM_END = IM_BASE + (32'(IM_WORDS) << 2);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        fault;
  } if_id_t;

  if_id_t      q;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] p4;
  logic [31:0] br_off;
  logic [1:0]  sel;
  logic        fault;

  assign im_addr     = pc;
  assign if_id_instr = q.instr;
  assign if_id_pc    = q.pc;
  assign if_id_valid = q.valid;
  assign if_id_fault = q.fault;

  assign fault = (pc[1:0] != 2'b00)
               | (pc < IM_BASE)
               | (pc >= IM_END);

  assign p4     = q.pc + 32'd4;
  assign br_off = {{14{q.instr[15]}}, q.instr[15:0], 2'b00};

  // ID can only steer the PC when it holds a real, legal fetch
  assign sel = (q.valid && !q.fault) ? npc_sel : 2'b00;

  always_comb begin
    pc_nxt = pc + 32'd4;
    unique case (1'b1)
      (sel == 2'b01): pc_nxt = p4 + br_off;
      (sel == 2'b10): pc_nxt = {p4[31:28], q.instr[25:0], 2'b00};
      (sel == 2'b11): pc_nxt = jr_target;
      default:        pc_nxt = pc + 32'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      q         <= '0;
      fetch_cnt <= '0;
    end else if (flush) begin
      q <= '0;
      if (!stall) pc <= pc_nxt;
    end else if (!stall) begin
      pc      <= pc_nxt;
      q.instr <= fault ? 32'd0 : im_rdata;
      q.pc    <= pc;
      q.valid <= 1'b1;
      q.fault <= fault;
      if (!fault && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table plus randomised
// stimulus checked against a behavioural reference through a queue.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        stall;
  logic        flush;
  logic [1:0]  npc_sel;
  logic [31:0] jr_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        if_id_fault;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .stall       (stall),
    .flush       (flush),
    .npc_sel     (npc_sel),
    .jr_target   (jr_target),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .if_id_fault (if_id_fault),
    .fetch_cnt   (fetch_cnt)
  );

  typedef struct {
    logic        r;
    logic        s;
    logic        f;
    logic [1:0]  sel;
    logic [31:0] jr;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        v;
    logic        flt;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        v;
    logic        flt;
    logic [31:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_v, m_f;

  task automatic addv(input logic r, s, f, input logic [1:0] sel,
                      input logic [31:0] jr, rd, addr, ipc, instr,
                      input logic v, flt, input logic [31:0] cnt);
    vec_t t;
    t.r = r; t.s = s; t.f = f; t.sel = sel; t.jr = jr; t.rd = rd;
    t.addr = addr; t.ipc = ipc; t.instr = instr;
    t.v = v; t.flt = flt; t.cnt = cnt;
    tbl.push_back(t);
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h", tag, fld, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "im_addr", im_addr, e.addr);
      chk(e.tag, "pc", if_id_pc, e.ipc);
      chk(e.tag, "instr", if_id_instr, e.instr);
      chk(e.tag, "valid", {31'd0, if_id_valid}, {31'd0, e.v});
      chk(e.tag, "fault", {31'd0, if_id_fault}, {31'd0, e.flt});
      chk(e.tag, "cnt", fetch_cnt, e.cnt);
    end
  endtask

  task automatic drive(input logic r, s, f, input logic [1:0] sel,
                       input logic [31:0] jr, rd);
    rst_n = r; stall = s; flush = f;
    npc_sel = sel; jr_target = jr; im_rdata = rd;
  endtask

  // Independent reference of one clock edge, applied to the m_* state
  task automatic model_step(input logic r, s, f, input logic [1:0] sel,
                            input logic [31:0] jr, rd);
    logic [31:0] p4, npc, old_pc;
    logic        flt;
    logic [1:0]  es;
    if (!r) begin
      m_pc = 32'h3000; m_ipc = 0; m_instr = 0;
      m_v = 0; m_f = 0; m_cnt = 0;
    end else begin
      old_pc = m_pc;
      flt = (old_pc[1:0] != 0) || (old_pc < 32'h3000) ||
            (old_pc >= 32'h7000);
      es = (m_v && !m_f) ? sel : 2'b00;
      p4 = m_ipc + 4;
      case (es)
        2'b01:   npc = p4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
        2'b10:   npc = {p4[31:28], m_instr[25:0], 2'b00};
        2'b11:   npc = jr;
        default: npc = old_pc + 4;
      endcase
      if (f) begin
        m_ipc = 0; m_instr = 0; m_v = 0; m_f = 0;
        if (!s) m_pc = npc;
      end else if (!s) begin
        m_pc = npc;
        m_ipc = old_pc;
        m_instr = flt ? 32'd0 : rd;
        m_v = 1;
        m_f = flt;
        if (!flt && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
  endtask

  initial begin
    exp_t e;
    drive(0, 0, 0, 2'b00, 0, 0);

    addv(0,0,0,0,0,0,              32'h3000,0,0,0,0,0);
    addv(0,0,0,0,0,0,              32'h3000,0,0,0,0,0);
    addv(1,0,0,0,0,32'h2401_0001,  32'h3004,32'h3000,32'h2401_0001,1,0,1);
    addv(1,0,0,0,0,32'h0,          32'h3008,32'h3004,32'h0,1,0,2);
    addv(1,0,0,0,0,32'h1000_FFFF,  32'h300C,32'h3008,32'h1000_FFFF,1,0,3);
    addv(1,0,0,1,0,32'h1111_1111,  32'h3008,32'h300C,32'h1111_1111,1,0,4);
    addv(1,0,0,0,0,32'h2222_2222,  32'h300C,32'h3008,32'h2222_2222,1,0,5);
    addv(1,0,0,3,32'h3FFC,32'h3333_3333,
                                   32'h3FFC,32'h300C,32'h3333_3333,1,0,6);
    addv(1,0,0,0,0,32'h0800_0C10,  32'h4000,32'h3FFC,32'h0800_0C10,1,0,7);
    addv(1,0,0,2,0,32'h4444_4444,  32'h3040,32'h4000,32'h4444_4444,1,0,8);
    addv(1,0,0,0,0,32'h5555_5555,  32'h3044,32'h3040,32'h5555_5555,1,0,9);
    addv(1,0,0,3,32'h3002,32'h6666_6666,
                                   32'h3002,32'h3044,32'h6666_6666,1,0,10);
    addv(1,0,0,0,0,32'h7777_7777,  32'h3006,32'h3002,32'h0,1,1,10);
    addv(1,0,0,3,32'h5000,32'h8888_8888,
                                   32'h300A,32'h3006,32'h0,1,1,10);
    addv(0,0,0,0,0,0,              32'h3000,0,0,0,0,0);
    addv(1,0,0,0,0,32'hA000_0000,  32'h3004,32'h3000,32'hA000_0000,1,0,1);
    addv(1,0,0,0,0,32'hA000_0001,  32'h3008,32'h3004,32'hA000_0001,1,0,2);
    addv(1,0,0,0,0,32'hA000_0002,  32'h300C,32'h3008,32'hA000_0002,1,0,3);
    addv(1,0,0,0,0,32'hA000_0003,  32'h3010,32'h300C,32'hA000_0003,1,0,4);
    for (int i = 0; i < 3; i++)
      addv(1,1,0,1,0,32'hBBBB_BBBB,32'h3010,32'h300C,32'hA000_0003,1,0,4);
    addv(1,1,1,0,0,32'hBBBB_BBBB,  32'h3010,0,0,0,0,4);
    addv(1,0,1,0,0,32'hCCCC_CCCC,  32'h3014,0,0,0,0,4);
    addv(1,0,0,0,0,32'hC000_0000,  32'h3018,32'h3014,32'hC000_0000,1,0,5);
    addv(1,0,0,0,0,32'h1000_FFFF,  32'h301C,32'h3018,32'h1000_FFFF,1,0,6);
    addv(1,1,0,1,0,32'h0,          32'h301C,32'h3018,32'h1000_FFFF,1,0,6);
    addv(0,1,0,1,0,32'h0,          32'h3000,0,0,0,0,0);
    addv(1,0,0,0,0,32'hD000_0000,  32'h3004,32'h3000,32'hD000_0000,1,0,1);
    addv(1,0,0,3,32'hFFFF_FFFC,32'hE000_0000,
                                   32'hFFFF_FFFC,32'h3004,32'hE000_0000,1,0,2);
    addv(1,0,0,0,0,32'hE000_0001,  32'h0,32'hFFFF_FFFC,32'h0,1,1,2);
    addv(1,0,0,0,0,32'hE000_0002,  32'h4,32'h0,32'h0,1,1,2);
    addv(0,0,0,0,0,0,              32'h3000,0,0,0,0,0);
    addv(1,0,0,0,0,32'hF000_0000,  32'h3004,32'h3000,32'hF000_0000,1,0,1);
    addv(1,0,0,3,32'h6FFC,32'hF000_0001,
                                   32'h6FFC,32'h3004,32'hF000_0001,1,0,2);
    addv(1,0,0,0,0,32'hF000_0002,  32'h7000,32'h6FFC,32'hF000_0002,1,0,3);
    addv(1,0,0,0,0,32'hF000_0003,  32'h7004,32'h7000,32'h0,1,1,3);
    addv(0,0,0,0,0,0,              32'h3000,0,0,0,0,0);
    addv(1,0,0,0,0,32'h1000_FFFF,  32'h3004,32'h3000,32'h1000_FFFF,1,0,1);
    addv(1,0,1,1,0,32'h0,          32'h3000,0,0,0,0,1);
    addv(1,0,0,1,0,32'h0000_0009,  32'h3004,32'h3000,32'h0000_0009,1,0,2);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].sel,
            tbl[i].jr, tbl[i].rd);
      e.tag = $sformatf("row%0d", i);
      e.addr = tbl[i].addr; e.ipc = tbl[i].ipc; e.instr = tbl[i].instr;
      e.v = tbl[i].v; e.flt = tbl[i].flt; e.cnt = tbl[i].cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
    end

    model_step(0, 0, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 2'b00, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      logic        r, s, f;
      logic [1:0]  sel;
      logic [31:0] jr, rd;
      r   = ($urandom_range(0, 39) != 0);
      s   = ($urandom_range(0, 4) == 0);
      f   = ($urandom_range(0, 7) == 0);
      sel = 2'($urandom_range(0, 3));
      jr  = ($urandom_range(0, 9) == 0) ? $urandom
          : 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
      rd  = $urandom;
      if ($urandom_range(0, 1) == 1)
        rd[15:0] = 16'($urandom_range(0, 15)) - 16'd8;
      drive(r, s, f, sel, jr, rd);
      model_step(r, s, f, sel, jr, rd);
      e.tag = $sformatf("rnd%0d", i);
      e.addr = m_pc; e.ipc = m_ipc; e.instr = m_instr;
      e.v = m_v; e.flt = m_f; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
